// File: rtl/stall_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stall_pipe_pkg
//  Purpose  : Shared constants and helpers for the elastic stall pipeline:
//             occupancy counter width and legal DEPTH range check.
//  Revision : 1.0 - initial release
// ============================================================================
package stall_pipe_pkg;

    localparam int MIN_DEPTH = 1;
    localparam int MAX_DEPTH = 16;

    // Width needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Elaboration-time legality test for the DEPTH parameter.
    function automatic bit depth_in_range(input int depth);
        return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stall_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage
//  Purpose  : One slot of the elastic pipeline: a valid bit plus a WIDTH-bit
//             data register. The slot loads from its source whenever it is
//             empty or its successor will take the current word this cycle.
//  Ports    : clk, rst (async, active-high), flush (sync)
//             src_valid/src_data - word offered by the previous slot
//             rdy_next           - ready of the following slot (or out_ready)
//             v/d                - registered valid and data of this slot
//             rdy                - this slot can take a word this cycle
//  Options  : PIPE_DATA_CLR_EN - zero the data register whenever the slot
//             ends up empty (flush or drain without refill).
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage
    import stall_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    input  logic             rdy_next,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             rdy
);

    // An empty slot is always ready; a full one only if its word moves on.
    assign rdy = ~v | rdy_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= 1'b0;
            d <= '0;
        end else if (flush) begin
            v <= 1'b0;
`ifdef PIPE_DATA_CLR_EN
            d <= '0;
`endif
        end else if (rdy) begin
            v <= src_valid;
            if (src_valid) begin
                d <= src_data;
            end
`ifdef PIPE_DATA_CLR_EN
            else begin
                d <= '0;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/stall_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : stall_pipe
//  Purpose  : Parametrised elastic register pipeline with per-stage valid
//             bits, valid/ready backpressure, bubble collapsing and a
//             synchronous flush. Full-throughput latency is DEPTH cycles.
//  Ports    : clk, rst (async, active-high), flush (sync, empties pipe)
//             in_valid/in_ready/in_data    - upstream handshake
//             out_valid/out_ready/out_data - downstream handshake
//             occupancy                    - number of valid stages
//  Options  : PIPE_DATA_CLR_EN - data of emptied stages is zeroed, so
//             out_data reads 0 whenever out_valid is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module stall_pipe
    import stall_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int                 c_OCC_W    = occ_width(DEPTH);
    localparam bit                 c_DEPTH_OK = depth_in_range(DEPTH);
    localparam logic [c_OCC_W-1:0] c_OCC_ONE  = c_OCC_W'(1);

    if (!c_DEPTH_OK) begin : g_depth_check
        $error("stall_pipe: DEPTH must be within 1..16");
    end

    // Index 0 is the pipeline input; index i+1 is the output of stage i.
    logic [DEPTH:0] w_vs;
    logic [WIDTH-1:0] w_ds [DEPTH+1];
    logic w_in_xfer;
    logic w_out_xfer;
    logic [c_OCC_W-1:0] r_occ;

    assign w_vs[0] = in_valid & ~flush;
    assign w_ds[0] = in_data;

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic w_rdy;
        logic w_rdy_nxt;

        // Ready ripples from the output back toward the input; each stage
        // owns its own net so the chain is not one self-referencing vector.
        if (gi == DEPTH - 1) begin : g_last
            assign w_rdy_nxt = out_ready;
        end else begin : g_inner
            assign w_rdy_nxt = g_stage[gi+1].w_rdy;
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .src_valid (w_vs[gi]),
            .src_data  (w_ds[gi]),
            .rdy_next  (w_rdy_nxt),
            .v         (w_vs[gi+1]),
            .d         (w_ds[gi+1]),
            .rdy       (w_rdy)
        );
    end

    // Held low during reset so nothing is accepted into a pipe being cleared.
    assign in_ready  = g_stage[0].w_rdy & ~flush & ~rst;
    assign out_valid = w_vs[DEPTH];
    assign out_data  = w_ds[DEPTH];

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    // Words only enter at stage 0 and leave at the last stage, so tracking
    // the two handshakes keeps the count equal to the number of set v bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + c_OCC_ONE;
        end else if (w_out_xfer && !w_in_xfer) begin
            r_occ <= r_occ - c_OCC_ONE;
        end
    end

    assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_stall_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stall_pipe
//  Purpose  : Self-checking bench for stall_pipe (DEPTH=4 and DEPTH=1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stall_pipe;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [2:0]  occupancy;

    logic        fl1, iv1, ir1, ov1, or1;
    logic [31:0] d1, q1;
    logic [0:0]  occ1;

    int n_checks = 0;
    int n_err    = 0;

    stall_pipe #(.WIDTH(32), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    stall_pipe #(.WIDTH(32), .DEPTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush(fl1),
        .in_valid(iv1), .in_ready(ir1), .in_data(d1),
        .out_valid(ov1), .out_ready(or1), .out_data(q1),
        .occupancy(occ1)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: ordered list of words (oldest first) with the stage
    // each currently sits in. Each edge the oldest may leave, and every word
    // moves one stage forward unless the word ahead of it blocks the slot.
    typedef struct {
        logic [31:0] data;
        int          pos;
    } slot_t;
    slot_t mq[$];

    task automatic step(input logic iv, input logic [31:0] dat,
                        input logic ordy, input logic fl);
        logic        e_ov, e_ir, oxf, ixf;
        logic [31:0] e_d;
        int          lim, np;
        @(negedge clk);
        in_valid = iv; in_data = dat; out_ready = ordy; flush = fl;
        #1;
        e_ov = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
        e_d  = e_ov ? mq[0].data : 32'h0;
        e_ir = !fl && (ordy || (mq.size() < DEPTH));
        chk("m_in_ready", 32'(in_ready), 32'(e_ir));
        chk("m_out_valid", 32'(out_valid), 32'(e_ov));
        if (e_ov) chk("m_out_data", out_data, e_d);
`ifdef PIPE_DATA_CLR_EN
        else chk("m_out_data_clr", out_data, 32'h0);
`endif
        chk("m_occupancy", 32'(occupancy), 32'(mq.size()));
        oxf = e_ov && ordy;
        ixf = iv && e_ir;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (oxf) void'(mq.pop_front());
            lim = DEPTH - 1;
            foreach (mq[k]) begin
                np = (mq[k].pos + 1 < lim) ? mq[k].pos + 1 : lim;
                mq[k].pos = np;
                lim = np - 1;
            end
            if (ixf) mq.push_back('{data: dat, pos: 0});
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        fl;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_dout;
        logic [2:0]  e_occ;
    } vec_t;
    vec_t tbl[22];

    initial begin
        // Backpressure: 6 offered with out_ready=0, then drain.
        tbl[0]  = '{1'b1, 32'h101, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   3'd0};
        tbl[1]  = '{1'b1, 32'h102, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   3'd1};
        tbl[2]  = '{1'b1, 32'h103, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   3'd2};
        tbl[3]  = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   3'd3};
        tbl[4]  = '{1'b1, 32'h105, 1'b0, 1'b0, 1'b0, 1'b1, 32'h101, 3'd4};
        tbl[5]  = '{1'b1, 32'h106, 1'b0, 1'b0, 1'b0, 1'b1, 32'h101, 3'd4};
        tbl[6]  = '{1'b1, 32'h105, 1'b1, 1'b0, 1'b1, 1'b1, 32'h101, 3'd4};
        tbl[7]  = '{1'b1, 32'h106, 1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 3'd4};
        tbl[8]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h103, 3'd4};
        tbl[9]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 3'd3};
        tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h105, 3'd2};
        tbl[11] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h106, 3'd1};
        tbl[12] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   3'd0};
        // Bubble collapse: 0x11, two idle cycles, 0x22, out_ready=0.
        tbl[13] = '{1'b1, 32'h11,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   3'd0};
        tbl[14] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   3'd1};
        tbl[15] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   3'd1};
        tbl[16] = '{1'b1, 32'h22,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   3'd1};
        tbl[17] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 32'h11,  3'd2};
        tbl[18] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 32'h11,  3'd2};
        // Third word, then flush with in_valid high.
        tbl[19] = '{1'b1, 32'h33,  1'b0, 1'b0, 1'b1, 1'b1, 32'h11,  3'd2};
        tbl[20] = '{1'b1, 32'h44,  1'b0, 1'b1, 1'b0, 1'b1, 32'h11,  3'd3};
        tbl[21] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   3'd0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        fl1 = 1'b0; iv1 = 1'b0; d1 = '0; or1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_d1_out_valid", 32'(ov1), 32'h0);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            in_valid = tbl[i].iv; in_data = tbl[i].din;
            out_ready = tbl[i].ordy; flush = tbl[i].fl;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov)
                chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_dout);
`ifdef PIPE_DATA_CLR_EN
            else
                chk($sformatf("tbl%0d_out_data_clr", i), out_data, 32'h0);
`endif
            chk($sformatf("tbl%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
            if (i == 19)
                chk("bubble_stage_valids", 32'(u_dut.w_vs[DEPTH:1]), 32'hC);
            @(posedge clk);
        end

        // Streaming 0x1..0x10 with out_ready high, then drain.
        for (int k = 1; k <= 16; k++) step(1'b1, 32'(k), 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 24) == 0);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Asynchronous reset with three words in flight.
        for (int k = 0; k < 3; k++) step(1'b1, 32'hBEEF_0000 + 32'(k), 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_occupancy", 32'(occupancy), 32'h0);
        chk("arst_out_data", out_data, 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h0);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b1;
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk($sformatf("post_rst_lat%0d_valid", c), 32'(out_valid), 32'(c == 4));
            if (c == 4) chk("post_rst_data", out_data, 32'hA5A5_0001);
        end
        @(negedge clk);
        #1 chk("post_rst_drained", 32'(occupancy), 32'h0);

        // DEPTH=1: one word in, one word out every cycle.
        @(negedge clk);
        iv1 = 1'b1; d1 = 32'h500; or1 = 1'b1;
        #1 chk("d1_first_in_ready", 32'(ir1), 32'h1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            d1 = 32'h500 + 32'(k);
            #1;
            chk("d1_in_ready", 32'(ir1), 32'h1);
            chk("d1_out_valid", 32'(ov1), 32'h1);
            chk("d1_out_data", q1, 32'h500 + 32'(k - 1));
            chk("d1_occupancy", 32'(occ1), 32'h1);
        end
        @(negedge clk);
        iv1 = 1'b0;
        #1 chk("d1_last_data", q1, 32'h508);
        @(negedge clk);
        #1 chk("d1_empty", 32'(ov1), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
